// File: rtl/memory_pkg.sv
// Shared data-memory constants, read-return FSM states and the memory command payload.
package memory_pkg;

   localparam int unsigned DATA_MEM_SIZE_BYTES  = 4096;
   localparam int unsigned DATA_MEM_SIZE_WORDS  = DATA_MEM_SIZE_BYTES / 4;
   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_M0 = 2'd1,
      RD_M1 = 2'd2
   } rd_state_e;

   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-master data memory arbiter: M0 priority with bounded M1 starvation,
// combinational grant and one-cycle read return routed back to the requester.
module data_mem_arbiter
   import memory_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [BE_W-1:0]   m0_be_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,

   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [BE_W-1:0]   m1_be_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [BE_W-1:0]   mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i
);

   localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   rd_state_e         state_q;
   logic [CNT_W-1:0]  starve_cnt_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;

   logic     accept_ok;
   logic     both_req;
   logic     m1_forced;
   logic     gnt0;
   logic     gnt1;
   mem_cmd_t m0_cmd;
   mem_cmd_t m1_cmd;
   mem_cmd_t mem_cmd;

   // Arbitration: M0 wins contention unless M1 has been starved STARVE_LIMIT times.
   always_comb begin
      accept_ok = 1'b0;
      both_req  = 1'b0;
      m1_forced = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      accept_ok = mem_ready_i & ~rst_i;
      both_req  = m0_req_i & m1_req_i;
      m1_forced = both_req & (starve_cnt_q == CNT_W'(STARVE_LIMIT));
      gnt0      = accept_ok & m0_req_i & ~m1_forced;
      gnt1      = accept_ok & m1_req_i & (~m0_req_i | m1_forced);
   end

   assign m0_cmd = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
   assign m1_cmd = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

   // Memory-side mux: granted master's command, all zero when idle.
   always_comb begin
      mem_cmd = '0;
      if (gnt0) begin
         mem_cmd = m0_cmd;
      end else if (gnt1) begin
         mem_cmd = m1_cmd;
      end
   end

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign mem_req_o   = gnt0 | gnt1;
   assign mem_we_o    = mem_cmd.we;
   assign mem_be_o    = mem_cmd.be;
   assign mem_addr_o  = mem_cmd.addr;
   assign mem_wdata_o = mem_cmd.wdata;

   // Return path: data passes straight through in the rvalid cycle, then is held.
   assign m0_rvalid_o = (state_q == RD_M0) & ~rst_i;
   assign m1_rvalid_o = (state_q == RD_M1) & ~rst_i;
   assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : m0_rdata_q;
   assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : m1_rdata_q;

   // Read-return FSM and per-master rdata capture; every state re-decides each cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         if (gnt0 && !m0_we_i) begin
            state_q <= RD_M0;
         end else if (gnt1 && !m1_we_i) begin
            state_q <= RD_M1;
         end else begin
            state_q <= IDLE;
         end
         if (state_q == RD_M0) begin
            m0_rdata_q <= mem_rdata_i;
         end
         if (state_q == RD_M1) begin
            m1_rdata_q <= mem_rdata_i;
         end
      end
   end

   // Starvation counter: counts contended M0 wins, saturating, cleared by any M1 grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_q <= '0;
      end else if (gnt1) begin
         starve_cnt_q <= '0;
      end else if (gnt0 && both_req && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
         starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
   end

endmodule
